// File: rtl/sprite_slot_loader.sv
// Slot-bus initiator for one sprite core: streams a bitmap from a synchronous ROM
// into sprite RAM and commits shadowed position/control updates at frame boundaries.
//
// state    | meaning
// IDLE     | no slot traffic; waits for start or frame_start with an update pending
// LOAD     | src_addr = idx; the RAM write for idx-1 is on the bus
// REG_BYP  | 0x2000 <- bypass on the bus
// REG_X    | 0x2001 <- x on the bus
// REG_Y    | 0x2002 <- y on the bus
// REG_CTRL | 0x2003 <- ctrl on the bus; shadow released, chained load may start
module sprite_slot_loader #(
  parameter int ADDR_WIDTH = 13,
  parameter int NPIX       = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [1:0]            src_data,
  input  logic                  frame_start,
  input  logic                  pos_valid,
  output logic                  pos_ready,
  input  logic                  pos_bypass,
  input  logic [10:0]           pos_x,
  input  logic [10:0]           pos_y,
  input  logic [4:0]            pos_ctrl,
  output logic                  cs,
  output logic                  write,
  output logic [13:0]           addr,
  output logic [31:0]           wr_data
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] REG_BYP  = 3'd2;
  localparam logic [2:0] REG_X    = 3'd3;
  localparam logic [2:0] REG_Y    = 3'd4;
  localparam logic [2:0] REG_CTRL = 3'd5;

  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(NPIX - 1);

  logic [2:0]            state;
  logic [ADDR_WIDTH:0]   idx;
  logic                  upd_pending;
  logic                  start_pending;
  logic                  wr_q;
  logic                  ram_wr_q;
  logic                  ram_last_q;
  logic                  done_q;
  logic [13:0]           addr_q;
  logic [31:0]           reg_data_q;
  logic                  sh_bypass;
  logic [10:0]           sh_x;
  logic [10:0]           sh_y;
  logic [4:0]            sh_ctrl;

  assign pos_ready = ~upd_pending;
  assign src_addr  = idx[ADDR_WIDTH-1:0];
  assign busy      = (state == LOAD) | ram_wr_q;
  assign done      = done_q;
  assign cs        = wr_q;
  assign write     = wr_q;
  assign addr      = addr_q;
  // ROM data lands in the same cycle as its registered RAM write strobe, so it is
  // steered straight onto the bus; registering it would cost a bubble per word.
  assign wr_data   = ram_wr_q ? {30'b0, src_data} : reg_data_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      idx           <= '0;
      upd_pending   <= 1'b0;
      start_pending <= 1'b0;
      wr_q          <= 1'b0;
      ram_wr_q      <= 1'b0;
      ram_last_q    <= 1'b0;
      done_q        <= 1'b0;
      addr_q        <= '0;
      reg_data_q    <= '0;
      sh_bypass     <= 1'b0;
      sh_x          <= '0;
      sh_y          <= '0;
      sh_ctrl       <= '0;
    end else begin
      wr_q       <= 1'b0;
      ram_wr_q   <= 1'b0;
      ram_last_q <= 1'b0;
      addr_q     <= '0;
      reg_data_q <= '0;
      done_q     <= ram_last_q;

      if (pos_valid && !upd_pending) begin
        sh_bypass   <= pos_bypass;
        sh_x        <= pos_x;
        sh_y        <= pos_y;
        sh_ctrl     <= pos_ctrl;
        upd_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (frame_start && upd_pending) begin
            state         <= REG_BYP;
            wr_q          <= 1'b1;
            addr_q        <= 14'h2000;
            reg_data_q    <= {31'b0, sh_bypass};
            start_pending <= start;
          end else if (start) begin
            state <= LOAD;
            idx   <= '0;
          end
        end
        LOAD: begin
          wr_q     <= 1'b1;
          ram_wr_q <= 1'b1;
          addr_q   <= 14'(idx[ADDR_WIDTH-1:0]);
          if (idx == LAST_IDX) begin
            ram_last_q <= 1'b1;
            state      <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        REG_BYP: begin
          state      <= REG_X;
          wr_q       <= 1'b1;
          addr_q     <= 14'h2001;
          reg_data_q <= {21'b0, sh_x};
          if (start) start_pending <= 1'b1;
        end
        REG_X: begin
          state      <= REG_Y;
          wr_q       <= 1'b1;
          addr_q     <= 14'h2002;
          reg_data_q <= {21'b0, sh_y};
          if (start) start_pending <= 1'b1;
        end
        REG_Y: begin
          state      <= REG_CTRL;
          wr_q       <= 1'b1;
          addr_q     <= 14'h2003;
          reg_data_q <= {27'b0, sh_ctrl};
          if (start) start_pending <= 1'b1;
        end
        REG_CTRL: begin
          upd_pending <= 1'b0;
          if (start_pending || start) begin
            state         <= LOAD;
            idx           <= '0;
            start_pending <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
